xfft_symbol_sched: RTL and testbench

- Per-symbol controller in front of the FFT core.
- Accepts symbol configuration requests (nFFT, CP length, scale, direction) and issues a core config word only when the configuration changes.
- Strips the cyclic prefix from a continuous sample stream and frames exactly 2^nFFT samples per symbol, with tlast, into the core's data input.
- Sits between the OFDM sample source and the FFT wrapper; replaces ad-hoc edge-detect config logic and free-running counters.

---
 rtl/xfft_pkg.sv | 37 +++
 rtl/xfft_symbol_sched.sv | 229 ++++++++++++++++++++++
 tb/tb_xfft_symbol_sched.sv | 323 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/xfft_pkg.sv
// Shared types and helpers for the FFT per-symbol scheduler.
// The symbol configuration struct, the core config word packing and the
// scheduler state encoding live here so the scheduler and anything that
// later talks to it agree on one definition.
package xfft_pkg;

   // Default legal log2 transform range of the FFT core.
   localparam int NFFT_MIN_DEF = 3;
   localparam int NFFT_MAX_DEF = 16;

   // Width of the cyclic-prefix length field carried in a symbol config.
   // The scheduler's CP_W parameter must match this value.
   localparam int SYM_CP_W = 10;

   // One symbol configuration request as held in the pending/active slots.
   typedef struct packed {
      logic [4:0]          nfft;
      logic [SYM_CP_W-1:0] cp_len;
      logic [7:0]          scale;
      logic                fwd_inv;
   } sym_cfg_t;

   // Scheduler phases: wait for a config, send it, drop CP, pass the symbol.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CFG  = 2'd1,
      DROP = 2'd2,
      PASS = 2'd3
   } sched_state_t;

   // Core config word. The prefix is stripped before the core, so the CP
   // field of the core word is always left at zero.
   function automatic logic [31:0] pack_cfg(input sym_cfg_t c);
      return {8'h00, c.scale, 7'h00, c.fwd_inv, 3'b000, c.nfft};
   endfunction

endpackage

// File: rtl/xfft_symbol_sched.sv
// Per-symbol controller in front of the FFT core.
// Holds one pending configuration request, promotes it to the active slot
// only at a symbol boundary, sends the core config word only when the
// transform settings differ from what the core last accepted, then drops
// cp_len input beats and forwards exactly 2^nfft beats with tlast.
module xfft_symbol_sched
   import xfft_pkg::*;
#(
   parameter int DATA_W   = 32,
   parameter int NFFT_MIN = NFFT_MIN_DEF,
   parameter int NFFT_MAX = NFFT_MAX_DEF,
   parameter int CP_W     = SYM_CP_W,
   parameter int CNT_W    = 16
) (
   input  logic              aclk,
   input  logic              areset,
   input  logic [4:0]        i_nfft,
   input  logic [CP_W-1:0]   i_cp_len,
   input  logic [7:0]        i_scale,
   input  logic              i_fwd_inv,
   input  logic              i_cfg_valid,
   output logic              o_cfg_ready,
   input  logic [DATA_W-1:0] s_tdata,
   input  logic              s_tvalid,
   output logic              s_tready,
   output logic [DATA_W-1:0] m_tdata,
   output logic              m_tvalid,
   input  logic              m_tready,
   output logic              m_tlast,
   output logic [31:0]       m_cfg_tdata,
   output logic              m_cfg_tvalid,
   input  logic              m_cfg_tready,
   output logic              o_busy,
   output logic              o_symbol_done,
   output logic [CNT_W-1:0]  o_sym_count,
   output logic              o_err_nfft
);

   localparam logic [NFFT_MAX-1:0] CNT_ONE = NFFT_MAX'(1);

   sched_state_t        state_q, state_d;
   sym_cfg_t            pend_q, act_q, eff_cfg;
   logic                pend_valid_q, act_valid_q, sent_valid_q;
   logic [4:0]          sent_nfft_q;
   logic [7:0]          sent_scale_q;
   logic                sent_fwd_q;
   logic [NFFT_MAX-1:0] cnt_q, cnt_d;
   logic                err_q, done_q;
   logic [CNT_W-1:0]    sym_cnt_q;

   logic                req_fire, req_legal;
   logic                eff_valid, cfg_changed;
   logic                act_load, sent_load, sym_fire;
   logic [NFFT_MAX:0]   sym_len, last_full;
   logic [NFFT_MAX-1:0] last_idx;
   logic                drop_end;

   // Request slot handshake and legality of the requested transform size.
   assign o_cfg_ready = ~pend_valid_q;
   assign req_fire    = i_cfg_valid & ~pend_valid_q;
   assign req_legal   = (i_nfft >= 5'(NFFT_MIN)) && (i_nfft <= 5'(NFFT_MAX));

   // In IDLE a waiting request takes effect this cycle, so decisions there
   // look through to the pending slot instead of the stale active one.
   assign eff_cfg   = (state_q == IDLE && pend_valid_q) ? pend_q : act_q;
   assign eff_valid = act_valid_q | ((state_q == IDLE) & pend_valid_q);

   assign cfg_changed = ~sent_valid_q ||
                        ({eff_cfg.nfft, eff_cfg.fwd_inv, eff_cfg.scale} !=
                         {sent_nfft_q, sent_fwd_q, sent_scale_q});

   // Index of the final beat, 2^nfft - 1, computed one bit wider so that
   // nfft == NFFT_MAX does not overflow before the subtraction.
   assign sym_len   = (NFFT_MAX + 1)'(1) << act_q.nfft;
   assign last_full = sym_len - (NFFT_MAX + 1)'(1);
   assign last_idx  = last_full[NFFT_MAX-1:0];

   // DROP is only entered with cp_len > 0, so cnt_q + 1 never wraps here.
   assign drop_end = (cnt_q + CNT_ONE) == NFFT_MAX'(act_q.cp_len);

   assign o_busy        = (state_q != IDLE);
   assign o_symbol_done = done_q;
   assign o_sym_count   = sym_cnt_q;
   assign o_err_nfft    = err_q;

   // Next-state, beat counter and stream/config handshake outputs.
   always_comb begin
      // NOTE: every signal driven here gets a default first, so no path
      // through the case can leave one unassigned and infer a latch.
      state_d      = state_q;
      cnt_d        = cnt_q;
      s_tready     = 1'b0;
      m_tvalid     = 1'b0;
      m_tdata      = '0;
      m_tlast      = 1'b0;
      m_cfg_tvalid = 1'b0;
      m_cfg_tdata  = '0;
      act_load     = 1'b0;
      sent_load    = 1'b0;
      sym_fire     = 1'b0;

      unique case (state_q)
         IDLE: begin
            act_load = pend_valid_q;
            cnt_d    = '0;
            if (eff_valid) begin
               if (cfg_changed) begin
                  state_d = CFG;
               end else if (eff_cfg.cp_len != '0) begin
                  state_d = DROP;
               end else begin
                  state_d = PASS;
               end
            end
         end

         CFG: begin
            m_cfg_tvalid = 1'b1;
            m_cfg_tdata  = pack_cfg(act_q);
            if (m_cfg_tready) begin
               sent_load = 1'b1;
               state_d   = (act_q.cp_len != '0) ? DROP : PASS;
            end
         end

         DROP: begin
            s_tready = 1'b1;
            if (s_tvalid) begin
               if (drop_end) begin
                  cnt_d   = '0;
                  state_d = PASS;
               end else begin
                  cnt_d = cnt_q + CNT_ONE;
               end
            end
         end

         PASS: begin
            m_tdata  = s_tdata;
            m_tvalid = s_tvalid;
            s_tready = m_tready;
            m_tlast  = (cnt_q == last_idx);
            if (s_tvalid && m_tready) begin
               if (cnt_q == last_idx) begin
                  cnt_d    = '0;
                  sym_fire = 1'b1;
                  state_d  = IDLE;
               end else begin
                  cnt_d = cnt_q + CNT_ONE;
               end
            end
         end

         default: state_d = IDLE;
      endcase
   end

   // State register and shared DROP/PASS beat counter.
   always_ff @(posedge aclk) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples the pre-edge values regardless of block order.
      if (areset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Slot valid flags and the sticky illegal-size error.
   always_ff @(posedge aclk) begin
      if (areset) begin
         pend_valid_q <= 1'b0;
         act_valid_q  <= 1'b0;
         sent_valid_q <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         if (act_load) begin
            pend_valid_q <= 1'b0;
            act_valid_q  <= 1'b1;
         end
         if (req_fire) begin
            if (req_legal) begin
               pend_valid_q <= 1'b1;
            end else begin
               err_q <= 1'b1;
            end
         end
         if (sent_load) begin
            sent_valid_q <= 1'b1;
         end
      end
   end

   // Configuration payloads, qualified by the valid flags above.
   always_ff @(posedge aclk) begin
      // NOTE: payload registers carry no reset; their valid flags are
      // cleared on reset, so stale contents are never acted upon.
      if (req_fire && req_legal) begin
         pend_q.nfft    <= i_nfft;
         pend_q.cp_len  <= i_cp_len;
         pend_q.scale   <= i_scale;
         pend_q.fwd_inv <= i_fwd_inv;
      end
      if (act_load) begin
         act_q <= pend_q;
      end
      if (sent_load) begin
         sent_nfft_q  <= act_q.nfft;
         sent_scale_q <= act_q.scale;
         sent_fwd_q   <= act_q.fwd_inv;
      end
   end

   // Symbol completion pulse and wrapping symbol counter.
   always_ff @(posedge aclk) begin
      if (areset) begin
         done_q    <= 1'b0;
         sym_cnt_q <= '0;
      end else begin
         done_q <= sym_fire;
         if (sym_fire) begin
            sym_cnt_q <= sym_cnt_q + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_xfft_symbol_sched.sv
// Directed bench for xfft_symbol_sched. Inputs change on the falling edge,
// outputs are sampled 1 ns later; each sampled handshake is logged as the
// transfer that the following rising edge completes.
module tb_xfft_symbol_sched;

   logic        aclk;
   logic        areset;
   logic [4:0]  i_nfft;
   logic [9:0]  i_cp_len;
   logic [7:0]  i_scale;
   logic        i_fwd_inv;
   logic        i_cfg_valid;
   logic        o_cfg_ready;
   logic [31:0] s_tdata;
   logic        s_tvalid;
   logic        s_tready;
   logic [31:0] m_tdata;
   logic        m_tvalid;
   logic        m_tready;
   logic        m_tlast;
   logic [31:0] m_cfg_tdata;
   logic        m_cfg_tvalid;
   logic        m_cfg_tready;
   logic        o_busy;
   logic        o_symbol_done;
   logic [15:0] o_sym_count;
   logic        o_err_nfft;

   xfft_symbol_sched dut (
      .aclk          (aclk),
      .areset        (areset),
      .i_nfft        (i_nfft),
      .i_cp_len      (i_cp_len),
      .i_scale       (i_scale),
      .i_fwd_inv     (i_fwd_inv),
      .i_cfg_valid   (i_cfg_valid),
      .o_cfg_ready   (o_cfg_ready),
      .s_tdata       (s_tdata),
      .s_tvalid      (s_tvalid),
      .s_tready      (s_tready),
      .m_tdata       (m_tdata),
      .m_tvalid      (m_tvalid),
      .m_tready      (m_tready),
      .m_tlast       (m_tlast),
      .m_cfg_tdata   (m_cfg_tdata),
      .m_cfg_tvalid  (m_cfg_tvalid),
      .m_cfg_tready  (m_cfg_tready),
      .o_busy        (o_busy),
      .o_symbol_done (o_symbol_done),
      .o_sym_count   (o_sym_count),
      .o_err_nfft    (o_err_nfft)
   );

   initial aclk = 1'b0;
   always #5 aclk = ~aclk;

   int          vectors;
   int          miscompares;
   int          src_idx;
   int          last_cnt;
   int          done_cnt;
   int          req_acc;
   int          cfg_total;
   bit          req_active;
   logic [31:0] out_data[$];
   logic        out_last[$];
   logic [31:0] cfg_q[$];
   logic        snap_s_tready;
   logic [31:0] snap_m_tdata;
   logic        snap_cfg_tvalid;
   logic [31:0] snap_cfg_tdata;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // One clock: drive, settle, log the handshakes of the coming edge.
   task automatic step(input bit sv, input bit mr, input bit cr);
      s_tvalid     = sv;
      s_tdata      = 32'(src_idx);
      m_tready     = mr;
      m_cfg_tready = cr;
      i_cfg_valid  = req_active;
      #1;
      snap_s_tready   = s_tready;
      snap_m_tdata    = m_tdata;
      snap_cfg_tvalid = m_cfg_tvalid;
      snap_cfg_tdata  = m_cfg_tdata;
      if (s_tvalid && s_tready) src_idx++;
      if (m_tvalid && m_tready) begin
         out_data.push_back(m_tdata);
         out_last.push_back(m_tlast);
         if (m_tlast) last_cnt++;
      end
      if (m_cfg_tvalid && m_cfg_tready) begin
         cfg_q.push_back(m_cfg_tdata);
         cfg_total++;
      end
      if (o_symbol_done) done_cnt++;
      if (req_active && o_cfg_ready) begin
         req_active = 1'b0;
         req_acc++;
      end
      @(negedge aclk);
   endtask

   task automatic request(input logic [4:0] n, input logic [9:0] cp,
                          input logic [7:0] sc, input logic fw);
      i_nfft     = n;
      i_cp_len   = cp;
      i_scale    = sc;
      i_fwd_inv  = fw;
      req_active = 1'b1;
   endtask

   task automatic clear_log();
      out_data.delete();
      out_last.delete();
      cfg_q.delete();
      last_cnt = 0;
      done_cnt = 0;
   endtask

   task automatic reset_dut();
      areset = 1'b1;
      step(1'b0, 1'b1, 1'b1);
      step(1'b0, 1'b1, 1'b1);
      areset     = 1'b0;
      req_active = 1'b0;
      cfg_total  = 0;
      clear_log();
   endtask

   task automatic run_frames(input string tag, input int n, input int budget, input bit rnd);
      int cyc;
      bit sv, mr;
      cyc = 0;
      while (last_cnt < n && cyc < budget) begin
         sv = rnd ? bit'($urandom_range(0, 1)) : 1'b1;
         mr = rnd ? bit'($urandom_range(0, 1)) : 1'b1;
         step(sv, mr, 1'b1);
         cyc++;
      end
      check({tag, "_frames"}, 32'(last_cnt), 32'(n));
   endtask

   task automatic run_beats(input string tag, input int n, input int budget);
      int cyc;
      cyc = 0;
      while (out_data.size() < n && cyc < budget) begin
         step(1'b1, 1'b1, 1'b1);
         cyc++;
      end
      check({tag, "_beats"}, 32'(out_data.size()), 32'(n));
   endtask

   initial begin
      int base, bad_d, bad_l, acc0, cyc;
      vectors = 0; miscompares = 0; src_idx = 0; req_acc = 0; cfg_total = 0;
      req_active = 1'b0;
      areset = 1'b1; i_nfft = '0; i_cp_len = '0; i_scale = '0; i_fwd_inv = 1'b0;
      i_cfg_valid = 1'b0; s_tdata = '0; s_tvalid = 1'b0; m_tready = 1'b0;
      m_cfg_tready = 1'b0;
      @(negedge aclk);
      reset_dut();

      // Reset state.
      #1;
      check("rst_cfg_ready", 32'(o_cfg_ready), 32'd1);
      check("rst_flags", {26'd0, o_busy, m_tvalid, m_tlast, m_cfg_tvalid, o_symbol_done, o_err_nfft}, 32'd0);
      check("rst_s_tready", 32'(s_tready), 32'd0);
      check("rst_sym_count", 32'(o_sym_count), 32'd0);
      check("rst_m_cfg_tdata", m_cfg_tdata, 32'd0);

      // Test 1: nfft=6 cp=16, two symbols of 80 input samples.
      clear_log();
      base = src_idx;
      request(5'd6, 10'd16, 8'hAA, 1'b1);
      run_frames("t1", 2, 400, 1'b0);
      check("t1_cfg_count", 32'(cfg_q.size()), 32'd1);
      check("t1_cfg_word", (cfg_q.size() > 0) ? cfg_q[0] : 32'hDEAD_BEEF, 32'h00AA_0106);
      check("t1_beats", 32'(out_data.size()), 32'd128);
      bad_d = 0; bad_l = 0;
      foreach (out_data[j]) begin
         if (out_data[j] !== 32'(base + 80 * (j / 64) + 16 + (j % 64))) bad_d++;
         if (out_last[j] !== ((j % 64) == 63)) bad_l++;
      end
      check("t1_data_errs", 32'(bad_d), 32'd0);
      check("t1_tlast_errs", 32'(bad_l), 32'd0);
      check("t1_first_sample", (out_data.size() > 0) ? out_data[0] : 32'hDEAD_BEEF, 32'(base + 16));
      #1;
      check("t1_sym_count", 32'(o_sym_count), 32'd2);
      @(negedge aclk);

      // Test 2: same config, three more symbols, no config resend.
      clear_log();
      base = src_idx;
      run_frames("t2", 3, 600, 1'b0);
      check("t2_cfg_total", 32'(cfg_total), 32'd1);
      step(1'b0, 1'b1, 1'b1);
      check("t2_done_pulses", 32'(done_cnt), 32'd3);
      bad_d = 0;
      foreach (out_data[j])
         if (out_data[j] !== 32'(base + 80 * (j / 64) + 16 + (j % 64))) bad_d++;
      check("t2_data_errs", 32'(bad_d), 32'd0);
      check("t2_sym_count", 32'(o_sym_count), 32'd5);

      // Test 3: nfft=7 cp=0 requested mid-symbol applies at the boundary.
      clear_log();
      base = src_idx;
      acc0 = req_acc;
      cyc = 0;
      while (out_data.size() < 30 && cyc < 200) begin
         step(1'b1, 1'b1, 1'b1);
         cyc++;
      end
      request(5'd7, 10'd0, 8'hAA, 1'b1);
      run_frames("t3", 2, 600, 1'b0);
      check("t3_req_accepted", 32'(req_acc - acc0), 32'd1);
      check("t3_cfg_count", 32'(cfg_q.size()), 32'd1);
      check("t3_cfg_word", (cfg_q.size() > 0) ? cfg_q[0] : 32'hDEAD_BEEF, 32'h00AA_0107);
      check("t3_beats", 32'(out_data.size()), 32'd192);
      bad_d = 0; bad_l = 0;
      foreach (out_data[j]) begin
         if (out_data[j] !== ((j < 64) ? 32'(base + 16 + j) : 32'(base + 80 + (j - 64)))) bad_d++;
         if (out_last[j] !== (j == 63 || j == 191)) bad_l++;
      end
      check("t3_data_errs", 32'(bad_d), 32'd0);
      check("t3_tlast_errs", 32'(bad_l), 32'd0);

      // Test 4: illegal nfft=2 is accepted, flagged and discarded.
      clear_log();
      acc0 = req_acc;
      request(5'd2, 10'd3, 8'h11, 1'b0);
      repeat (4) step(1'b0, 1'b1, 1'b1);
      check("t4_req_accepted", 32'(req_acc - acc0), 32'd1);
      #1;
      check("t4_err_nfft", 32'(o_err_nfft), 32'd1);
      check("t4_cfg_ready", 32'(o_cfg_ready), 32'd1);
      @(negedge aclk);
      run_frames("t4", 1, 300, 1'b0);
      check("t4_cfg_count", 32'(cfg_q.size()), 32'd0);
      check("t4_beats", 32'(out_data.size()), 32'd128);
      check("t4_tlast_127", (out_last.size() == 128) ? 32'(out_last[127]) : 32'hDEAD_BEEF, 32'd1);

      // Test 5: nfft=4 cp=4, clean stream then random stalls and gaps.
      reset_dut();
      #1;
      check("t5_err_cleared", 32'(o_err_nfft), 32'd0);
      @(negedge aclk);
      base = src_idx;
      request(5'd4, 10'd4, 8'h55, 1'b0);
      run_frames("t5a", 2, 200, 1'b0);
      check("t5_cfg_word", (cfg_q.size() > 0) ? cfg_q[0] : 32'hDEAD_BEEF, 32'h0055_0004);
      bad_d = 0; bad_l = 0;
      foreach (out_data[j]) begin
         if (out_data[j] !== 32'(base + 20 * (j / 16) + 4 + (j % 16))) bad_d++;
         if (out_last[j] !== ((j % 16) == 15)) bad_l++;
      end
      check("t5a_beats", 32'(out_data.size()), 32'd32);
      check("t5a_errs", 32'(bad_d + bad_l), 32'd0);
      clear_log();
      base = src_idx;
      run_frames("t5b", 2, 2000, 1'b1);
      bad_d = 0; bad_l = 0;
      foreach (out_data[j]) begin
         if (out_data[j] !== 32'(base + 20 * (j / 16) + 4 + (j % 16))) bad_d++;
         if (out_last[j] !== ((j % 16) == 15)) bad_l++;
      end
      check("t5b_beats", 32'(out_data.size()), 32'd32);
      check("t5b_data_errs", 32'(bad_d), 32'd0);
      check("t5b_tlast_errs", 32'(bad_l), 32'd0);
      check("t5b_cfg_count", 32'(cfg_q.size()), 32'd0);

      // Test 6: config backpressure, then reset in PASS at beat 30.
      reset_dut();
      acc0 = req_acc;
      request(5'd5, 10'd0, 8'h0F, 1'b1);
      cyc = 0;
      while (req_acc == acc0 && cyc < 10) begin
         step(1'b1, 1'b1, 1'b0);
         cyc++;
      end
      step(1'b1, 1'b1, 1'b0);
      base = src_idx;
      bad_d = 0;
      repeat (20) begin
         step(1'b1, 1'b1, 1'b0);
         if (snap_s_tready !== 1'b0 || snap_m_tdata !== 32'd0 ||
             snap_cfg_tvalid !== 1'b1 || snap_cfg_tdata !== 32'h000F_0105) bad_d++;
      end
      check("t6_stall_errs", 32'(bad_d), 32'd0);
      check("t6_no_input_taken", 32'(src_idx - base), 32'd0);
      check("t6_cfg_held", 32'(cfg_q.size()), 32'd0);
      run_beats("t6", 30, 100);
      check("t6_cfg_word", (cfg_q.size() > 0) ? cfg_q[0] : 32'hDEAD_BEEF, 32'h000F_0105);
      areset = 1'b1;
      step(1'b1, 1'b1, 1'b1);
      areset = 1'b0;
      #1;
      check("t6_rst_flags", {26'd0, o_busy, m_tvalid, m_tlast, m_cfg_tvalid, o_symbol_done, s_tready}, 32'd0);
      check("t6_rst_cfg_ready", 32'(o_cfg_ready), 32'd1);
      check("t6_no_tlast", 32'(last_cnt), 32'd0);
      @(negedge aclk);
      clear_log();
      request(5'd5, 10'd0, 8'h0F, 1'b1);
      run_frames("t6b", 1, 200, 1'b0);
      check("t6b_cfg_count", 32'(cfg_q.size()), 32'd1);
      check("t6b_cfg_word", (cfg_q.size() > 0) ? cfg_q[0] : 32'hDEAD_BEEF, 32'h000F_0105);
      check("t6b_beats", 32'(out_data.size()), 32'd32);
      check("t6b_tlast_31", (out_last.size() == 32) ? 32'(out_last[31]) : 32'hDEAD_BEEF, 32'd1);
      #1;
      check("t6b_sym_count", 32'(o_sym_count), 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
